// File: rtl/dco_ctrl_pkg.sv
// rtl/dco_ctrl_pkg.sv - shared types and reset constants for the ADPLL loop controller
package dco_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        TRACK  = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    // Search starts mid-range with a quarter-range first step.
    function automatic int code_mid(input int code_w);
        return 1 << (code_w - 1);
    endfunction

    function automatic int step_init(input int code_w);
        return 1 << (code_w - 2);
    endfunction

endpackage

// File: rtl/dco_ctrl_flag_sync.sv
// rtl/dco_ctrl_flag_sync.sv - flag synchroniser with one-cycle rising-edge pulse
module flag_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flag,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain  <= '0;
            last_q <= 1'b0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], flag};
            last_q <= chain[SYNC_STAGES-1];
        end
    end

    // Edge taken off the last stage so the pulse is ready one cycle after it settles.
    assign pulse = chain[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/dco_ctrl.sv
// rtl/dco_ctrl.sv - binary-search acquisition and +/-1 tracking DCO loop controller
module dco_ctrl
    import dco_ctrl_pkg::*;
#(
    parameter int CODE_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_RUN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flagu,
    input  logic              flagd,
    output logic [CODE_W-1:0] dco_code,
    output logic              lock,
    output logic [1:0]        state
);

    localparam int AW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(UNLOCK_RUN + 1);

    localparam logic [CODE_W-1:0] CODE_MID  = CODE_W'(code_mid(CODE_W));
    localparam logic [CODE_W-1:0] CODE_MAX  = '1;
    localparam logic [CODE_W-1:0] CODE_ONE  = CODE_W'(1);
    localparam logic [CODE_W-2:0] STEP_INIT = (CODE_W-1)'(step_init(CODE_W));
    localparam logic [CODE_W-2:0] STEP_ONE  = (CODE_W-1)'(1);
    localparam logic [AW-1:0]     ALT_MAX   = AW'(LOCK_CNT);
    localparam logic [AW-1:0]     ALT_ONE   = AW'(1);
    localparam logic [RW-1:0]     RUN_MAX   = RW'(UNLOCK_RUN);
    localparam logic [RW-1:0]     RUN_ONE   = RW'(1);

    logic up_ev, dn_ev, ev;
    dir_t ev_dir;

    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-2:0] step_q, step_d;
    state_t            st_q, st_d;
    logic              lock_q, lock_d;
    logic [AW-1:0]     alt_q, alt_d;
    logic [RW-1:0]     run_q, run_d;
    dir_t              prev_q, prev_d;
    logic              has_prev_q, has_prev_d;

    flag_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
        .clk  (clk),
        .rst  (rst),
        .flag (flagu),
        .pulse(up_ev)
    );

    flag_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dn (
        .clk  (clk),
        .rst  (rst),
        .flag (flagd),
        .pulse(dn_ev)
    );

    // Coincident up/down events carry no phase information and cancel out.
    assign ev     = up_ev ^ dn_ev;
    assign ev_dir = up_ev ? DIR_UP : DIR_DN;

    always_comb begin
        code_d     = code_q;
        step_d     = step_q;
        st_d       = st_q;
        lock_d     = lock_q;
        alt_d      = alt_q;
        run_d      = run_q;
        prev_d     = prev_q;
        has_prev_d = has_prev_q;

        if (en) begin
            case (st_q)
                IDLE: st_d = SEARCH;
                SEARCH: begin
                    if (ev) begin
                        code_d = (ev_dir == DIR_UP) ? code_q + {1'b0, step_q}
                                                    : code_q - {1'b0, step_q};
                        step_d = step_q >> 1;
                        if (step_q == STEP_ONE) st_d = TRACK;
                    end
                end
                TRACK: begin
                    if (ev) begin
                        if (ev_dir == DIR_UP)
                            code_d = (code_q == CODE_MAX) ? code_q : code_q + CODE_ONE;
                        else
                            code_d = (code_q == '0) ? code_q : code_q - CODE_ONE;

                        if (!has_prev_q) begin
                            alt_d = '0;
                            run_d = RUN_ONE;
                        end else if (ev_dir != prev_q) begin
                            alt_d = (alt_q == ALT_MAX) ? alt_q : alt_q + ALT_ONE;
                            run_d = RUN_ONE;
                        end else begin
                            alt_d = '0;
                            run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
                        end
                        prev_d     = ev_dir;
                        has_prev_d = 1'b1;

                        // A sustained one-sided run means the loop has slipped.
                        if (run_d == RUN_MAX) begin
                            lock_d = 1'b0;
                            alt_d  = '0;
                        end else if (alt_d == ALT_MAX) begin
                            lock_d = 1'b1;
                        end
                    end
                end
                default: st_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q     <= CODE_MID;
            step_q     <= STEP_INIT;
            st_q       <= IDLE;
            lock_q     <= 1'b0;
            alt_q      <= '0;
            run_q      <= '0;
            prev_q     <= DIR_UP;
            has_prev_q <= 1'b0;
        end else begin
            code_q     <= code_d;
            step_q     <= step_d;
            st_q       <= st_d;
            lock_q     <= lock_d;
            alt_q      <= alt_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            has_prev_q <= has_prev_d;
        end
    end

    assign dco_code = code_q;
    assign lock     = lock_q;
    assign state    = st_q;

endmodule

// File: tb/tb_dco_ctrl.sv
// tb/tb_dco_ctrl.sv - randomized self-checking bench for dco_ctrl against a behavioural loop model
module tb_dco_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, flagu, flagd;
    logic [7:0] dco_code;
    logic       lock;
    logic [1:0] state;

    int vectors     = 0;
    int miscompares = 0;

    int m_code, m_step, m_state;
    bit m_lock;
    bit hist[$];

    dco_ctrl #(
        .CODE_W     (8),
        .SYNC_STAGES(2),
        .LOCK_CNT   (16),
        .UNLOCK_RUN (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flagu   (flagu),
        .flagd   (flagd),
        .dco_code(dco_code),
        .lock    (lock),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_code  = 128;
        m_step  = 64;
        m_state = 0;
        m_lock  = 0;
        hist.delete();
    endtask

    // Loop behaviour from the event history: run = trailing same-direction length,
    // alt = trailing count of direction changes.
    task automatic model_event(input bit up);
        int run, alt;
        if (m_state == 1) begin
            m_code = up ? m_code + m_step : m_code - m_step;
            m_step = m_step / 2;
            if (m_step == 0) m_state = 2;
        end else if (m_state == 2) begin
            if (up) m_code = (m_code >= 255) ? 255 : m_code + 1;
            else    m_code = (m_code <= 0) ? 0 : m_code - 1;
            hist.push_back(up);
            run = 1;
            for (int i = hist.size() - 2; i >= 0; i--) begin
                if (hist[i] != hist[i+1]) break;
                run++;
            end
            alt = 0;
            for (int i = hist.size() - 1; i >= 1; i--) begin
                if (hist[i] == hist[i-1]) break;
                alt++;
            end
            if (run >= 4)       m_lock = 0;
            else if (alt >= 16) m_lock = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; en = 0; flagu = 0; flagd = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic start_loop();
        @(negedge clk);
        en = 1;
        @(posedge clk);
        if (m_state == 0) m_state = 1;
        @(negedge clk);
    endtask

    // Drives one flag pulse; early = code one edge before the update edge, at_edge = code on it.
    task automatic pulse(input bit up, input bit dn, output logic [7:0] early, output logic [7:0] at_edge);
        @(negedge clk);
        flagu = up; flagd = dn;
        @(posedge clk);
        @(posedge clk); #1 early = dco_code;
        @(posedge clk); #1 at_edge = dco_code;
        if (en && (up ^ dn)) model_event(up);
        @(negedge clk);
        flagu = 0; flagd = 0;
        repeat ($urandom_range(2, 4)) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; en = 0; flagu = 0; flagd = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (dco_code !== 8'd128) begin miscompares++; $display("FAIL reset_code: got %0d expected 128", dco_code); end
        vectors++; if (lock !== 1'b0) begin miscompares++; $display("FAIL reset_lock: got %0b expected 0", lock); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
        @(negedge clk);
        rst = 0;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL idle_hold_en_low: got %0d expected 0", state); end
    endtask

    task automatic test_acq_all_up();
        int exp_code[7] = '{192, 224, 240, 248, 252, 254, 255};
        logic [7:0] early, at_edge;
        int prev;
        do_reset();
        start_loop();
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL idle_to_search: got %0d expected 1", state); end
        for (int i = 0; i < 7; i++) begin
            prev = m_code;
            pulse(1, 0, early, at_edge);
            vectors++; if (early !== prev[7:0]) begin miscompares++; $display("FAIL up_latency_early[%0d]: got %0d expected %0d", i, early, prev); end
            vectors++; if (at_edge !== exp_code[i]) begin miscompares++; $display("FAIL up_code[%0d]: got %0d expected %0d", i, at_edge, exp_code[i]); end
            vectors++; if (state !== m_state[1:0]) begin miscompares++; $display("FAIL up_state[%0d]: got %0d expected %0d", i, state, m_state); end
        end
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL up_track: got %0d expected 2", state); end
        vectors++; if (lock !== 1'b0) begin miscompares++; $display("FAIL up_lock: got %0b expected 0", lock); end
    endtask

    task automatic test_saturation_cancel();
        logic [7:0] early, at_edge;
        pulse(1, 0, early, at_edge);
        vectors++; if (dco_code !== 8'd255) begin miscompares++; $display("FAIL sat_top: got %0d expected 255", dco_code); end
        pulse(1, 1, early, at_edge);
        vectors++; if (dco_code !== m_code[7:0]) begin miscompares++; $display("FAIL cancel_code: got %0d expected %0d", dco_code, m_code); end
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL cancel_state: got %0d expected 2", state); end
    endtask

    task automatic test_lock();
        logic [7:0] early, at_edge;
        int base;
        for (int i = 0; i < 16; i++) begin
            pulse(i % 2 == 1, i % 2 == 0, early, at_edge);
            vectors++; if (lock !== m_lock) begin miscompares++; $display("FAIL lock_alt[%0d]: got %0b expected %0b", i, lock, m_lock); end
            vectors++; if (dco_code !== m_code[7:0]) begin miscompares++; $display("FAIL lock_code[%0d]: got %0d expected %0d", i, dco_code, m_code); end
        end
        vectors++; if (lock !== 1'b1) begin miscompares++; $display("FAIL lock_on_16th: got %0b expected 1", lock); end
        base = m_code;
        for (int j = 0; j < 4; j++) begin
            pulse(0, 1, early, at_edge);
            vectors++; if (lock !== (j < 3)) begin miscompares++; $display("FAIL unlock_run[%0d]: got %0b expected %0b", j, lock, j < 3); end
        end
        vectors++; if (dco_code !== 8'(base - 4)) begin miscompares++; $display("FAIL unlock_code: got %0d expected %0d", dco_code, base - 4); end
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL unlock_state: got %0d expected 2", state); end
    endtask

    task automatic test_acq_mixed();
        int exp_code[7] = '{192, 160, 176, 168, 172, 170, 171};
        logic [7:0] early, at_edge;
        do_reset();
        start_loop();
        for (int i = 0; i < 7; i++) begin
            pulse(i % 2 == 0, i % 2 == 1, early, at_edge);
            vectors++; if (at_edge !== exp_code[i]) begin miscompares++; $display("FAIL mixed_code[%0d]: got %0d expected %0d", i, at_edge, exp_code[i]); end
            vectors++; if (at_edge !== m_code[7:0]) begin miscompares++; $display("FAIL mixed_model[%0d]: got %0d expected %0d", i, at_edge, m_code); end
        end
        vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL mixed_track: got %0d expected 2", state); end
    endtask

    task automatic test_enable_freeze();
        logic [7:0] early, at_edge;
        @(negedge clk);
        en = 0;
        pulse(1, 0, early, at_edge);
        vectors++; if (dco_code !== m_code[7:0]) begin miscompares++; $display("FAIL freeze_code: got %0d expected %0d", dco_code, m_code); end
        vectors++; if (state !== m_state[1:0]) begin miscompares++; $display("FAIL freeze_state: got %0d expected %0d", state, m_state); end
        @(negedge clk);
        flagu = 1;
        repeat (4) @(negedge clk);
        en = 1;
        repeat (6) @(negedge clk);
        vectors++; if (dco_code !== m_code[7:0]) begin miscompares++; $display("FAIL no_stale_edge: got %0d expected %0d", dco_code, m_code); end
        flagu = 0;
        repeat (3) @(negedge clk);
        pulse(0, 1, early, at_edge);
        vectors++; if (dco_code !== m_code[7:0]) begin miscompares++; $display("FAIL resume_code: got %0d expected %0d", dco_code, m_code); end
    endtask

    task automatic test_random();
        logic [7:0] early, at_edge;
        bit dir = 0;
        int r;
        do_reset();
        start_loop();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                pulse(1, 1, early, at_edge);
            end else begin
                dir = (r < 4) ? dir : ~dir;
                if (i < 7) dir = $urandom_range(0, 1);
                pulse(dir, ~dir, early, at_edge);
            end
            vectors++; if (at_edge !== m_code[7:0]) begin miscompares++; $display("FAIL rand_code[%0d]: got %0d expected %0d", i, at_edge, m_code); end
            vectors++; if (lock !== m_lock) begin miscompares++; $display("FAIL rand_lock[%0d]: got %0b expected %0b", i, lock, m_lock); end
            vectors++; if (state !== m_state[1:0]) begin miscompares++; $display("FAIL rand_state[%0d]: got %0d expected %0d", i, state, m_state); end
        end
    endtask

    task automatic test_reset_mid_search();
        logic [7:0] early, at_edge;
        do_reset();
        start_loop();
        for (int i = 0; i < 3; i++) pulse($urandom_range(0, 1), 0, early, at_edge);
        @(negedge clk);
        rst = 1; flagu = 1;
        @(posedge clk); #1;
        vectors++; if (dco_code !== 8'd128) begin miscompares++; $display("FAIL mid_reset_code: got %0d expected 128", dco_code); end
        vectors++; if (lock !== 1'b0) begin miscompares++; $display("FAIL mid_reset_lock: got %0b expected 0", lock); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL mid_reset_state: got %0d expected 0", state); end
        @(negedge clk);
        rst = 0; flagu = 0;
    endtask

    initial begin
        rst = 1; en = 0; flagu = 0; flagd = 0;
        model_reset();
        test_reset();
        test_acq_all_up();
        test_saturation_cancel();
        test_lock();
        test_acq_mixed();
        test_enable_freeze();
        test_random();
        test_reset_mid_search();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
